regfile_wb_arbiter: RTL

- Shares the single write port of the 32 x 64-bit register file between two writeback requesters: the ALU stage and the load/store stage.
- Accepts one request per slot through a valid/ready handshake and captures the register index and data.
- Sequences the file's level-sensitive write port:
  - RegWrite held high for a programmable number of cycles, with index and data stable;
  - then one mandatory low cycle before the next write.
- A starvation counter stops the higher-priority load/store path from locking out the ALU.

---
 rtl/regfile_wb_arbiter_if.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 99 +++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/LSU requesters, the arbiter and the register file write port.
// master: requester/file side, slave: arbiter side.
interface regfile_wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [63:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_reg;
  logic [63:0] lsu_data;
  logic        lsu_ready;
  logic [4:0]  writereg;
  logic [63:0] writedata;
  logic        RegWrite;
  logic        busy;

  modport master (
    output alu_valid, alu_reg, alu_data,
    input  alu_ready,
    output lsu_valid, lsu_reg, lsu_data,
    input  lsu_ready,
    input  writereg, writedata, RegWrite, busy
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    output alu_ready,
    input  lsu_valid, lsu_reg, lsu_data,
    output lsu_ready,
    output writereg, writedata, RegWrite, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU and LSU writeback, holding RegWrite
// for HOLD_CYCLES cycles followed by one idle gap cycle; an age counter prevents ALU starvation.
module regfile_wb_arbiter #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned AGE_LIMIT   = 3
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;

  localparam logic [3:0] HoldInit = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] AgeLimit = 4'(AGE_LIMIT);

  logic [1:0]  state_q, state_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic [3:0]  age_cnt_q, age_cnt_d;
  logic [4:0]  writereg_q, writereg_d;
  logic [63:0] writedata_q, writedata_d;
  logic        regwrite_q, regwrite_d;

  logic grant_window;
  logic alu_win;
  logic lsu_win;

  always_comb begin
    grant_window = ((state_q == StIdle) || (state_q == StGap)) && !reset;
    // LSU has priority unless the ALU has lost AGE_LIMIT times in a row.
    alu_win = grant_window && bus.alu_valid && (!bus.lsu_valid || (age_cnt_q >= AgeLimit));
    lsu_win = grant_window && bus.lsu_valid && !alu_win;
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    writereg_d  = writereg_q;
    writedata_d = writedata_q;

    if (alu_win || lsu_win) begin
      state_d     = StWrite;
      hold_cnt_d  = HoldInit;
      writereg_d  = alu_win ? bus.alu_reg : bus.lsu_reg;
      writedata_d = alu_win ? bus.alu_data : bus.lsu_data;
    end else begin
      case (state_q)
        StWrite: begin
          if (hold_cnt_q == 4'd0) begin
            state_d = StGap;
          end else begin
            hold_cnt_d = hold_cnt_q - 4'd1;
          end
        end
        StGap:   state_d = StIdle;
        default: state_d = state_q;
      endcase
    end

    regwrite_d = (state_d == StWrite);
  end

  always_comb begin
    age_cnt_d = age_cnt_q;
    if (alu_win) begin
      age_cnt_d = 4'd0;
    end else if (lsu_win && bus.alu_valid && (age_cnt_q != 4'hF)) begin
      age_cnt_d = age_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      hold_cnt_q  <= 4'd0;
      age_cnt_q   <= 4'd0;
      writereg_q  <= 5'd0;
      writedata_q <= 64'd0;
      regwrite_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      age_cnt_q   <= age_cnt_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
      regwrite_q  <= regwrite_d;
    end
  end

  assign bus.alu_ready = alu_win;
  assign bus.lsu_ready = lsu_win;
  assign bus.writereg  = writereg_q;
  assign bus.writedata = writedata_q;
  assign bus.RegWrite  = regwrite_q;
  assign bus.busy      = (state_q != StIdle);

endmodule
